// File: rtl/mul_sequencer_pkg.sv
// Shared encodings for the shift-add multiply sequencer: FSM states,
// multiply type codes and the bit positions inside mul_type.
// No logic; imported by mul_sequencer and mul_operand_prep.
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_SIGN = 2'd2,
        S_WB   = 2'd3
    } state_t;

    localparam logic [1:0] MT_MULI  = 2'd0;
    localparam logic [1:0] MT_MULR  = 2'd1;
    localparam logic [1:0] MT_MULSI = 2'd2;
    localparam logic [1:0] MT_MULSR = 2'd3;

    // mul_type[MT_REG_BIT]: 1 = register operand B, 0 = immediate
    // mul_type[MT_SIGNED_BIT]: 1 = signed multiply
    localparam int MT_REG_BIT    = 0;
    localparam int MT_SIGNED_BIT = 1;

endpackage

// File: rtl/mul_operand_prep.sv
// Operand preparation: selects B (register or extended immediate) and
// produces |A|, |B| and the result sign. Purely combinational, zero latency.
// Ports: mul_type/op_a/op_b/imm in; mag_a/mag_b/neg out. No backpressure.
module mul_operand_prep
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16
) (
    input  logic [1:0]        mul_type,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [IMM_W-1:0]  imm,
    output logic [DATA_W-1:0] mag_a,
    output logic [DATA_W-1:0] mag_b,
    output logic              neg
);

    logic              is_signed;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] b_sel;

    assign is_signed = mul_type[MT_SIGNED_BIT];

    // The immediate follows the signedness of the multiply itself.
    assign imm_ext = is_signed ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                               : {{(DATA_W-IMM_W){1'b0}}, imm};

    assign b_sel = mul_type[MT_REG_BIT] ? op_b : imm_ext;

    // The most-negative value maps onto itself; the unsigned magnitude
    // is still exact, so the final product is correct mod 2^DATA_W.
    assign mag_a = (is_signed && op_a[DATA_W-1])  ? -op_a  : op_a;
    assign mag_b = (is_signed && b_sel[DATA_W-1]) ? -b_sel : b_sel;
    assign neg   = is_signed & (op_a[DATA_W-1] ^ b_sel[DATA_W-1]);

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier: one partial product per cycle, fixed
// latency (write-back DATA_W+2 cycles after the accepting edge).
// Holds decode via stall while busy; start during busy is ignored; flush aborts.
// Ports: clk/rst (async active-low), request (start, mul_type, dest_reg,
// op_a, op_b, imm, set_flags, flush), status (busy, stall), write-back
// (wr_en, wr_addr, wr_data, flag_we, flag_n, flag_z, done).
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMM_W      = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mul_type,
    input  logic [REG_ADDR_W-1:0] dest_reg,
    input  logic [DATA_W-1:0]     op_a,
    input  logic [DATA_W-1:0]     op_b,
    input  logic [IMM_W-1:0]      imm,
    input  logic                  set_flags,
    input  logic                  flush,
    output logic                  busy,
    output logic                  stall,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic                  flag_we,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                state, state_nxt;
    logic                  accept;
    logic                  in_wb;

    logic [DATA_W-1:0]     acc;
    logic [DATA_W-1:0]     mcand;
    logic [DATA_W-1:0]     mplier;
    logic [CNT_W-1:0]      cnt;
    logic                  neg_q;
    logic                  set_flags_q;
    logic [REG_ADDR_W-1:0] dest_q;

    logic [DATA_W-1:0]     prep_mag_a;
    logic [DATA_W-1:0]     prep_mag_b;
    logic                  prep_neg;

    mul_operand_prep #(
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_prep (
        .mul_type (mul_type),
        .op_a     (op_a),
        .op_b     (op_b),
        .imm      (imm),
        .mag_a    (prep_mag_a),
        .mag_b    (prep_mag_b),
        .neg      (prep_neg)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != S_IDLE);
        end
    end

    // Next state and decoded strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        in_wb     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && !flush) begin
                    accept    = 1'b1;
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                if (flush)              state_nxt = S_IDLE;
                else if (cnt == CNT_LAST) state_nxt = S_SIGN;
            end
            S_SIGN: begin
                state_nxt = flush ? S_IDLE : S_WB;
            end
            S_WB: begin
                // The write in this cycle completes even under flush.
                in_wb     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration and sign fix-up
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            cnt         <= '0;
            neg_q       <= 1'b0;
            set_flags_q <= 1'b0;
            dest_q      <= '0;
        end else if (accept) begin
            acc         <= '0;
            mcand       <= prep_mag_a;
            mplier      <= prep_mag_b;
            cnt         <= '0;
            neg_q       <= prep_neg;
            set_flags_q <= set_flags;
            dest_q      <= dest_reg;
        end else if (state == S_ITER) begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end else if (state == S_SIGN) begin
            if (neg_q) acc <= -acc;
        end
    end

    // Write-back outputs are held at zero outside the WB cycle so idle
    // and reset present a clean all-zero interface.
    assign wr_en   = in_wb;
    assign done    = in_wb;
    assign wr_addr = in_wb ? dest_q : '0;
    assign wr_data = in_wb ? acc : '0;
    assign flag_we = in_wb & set_flags_q;
    assign flag_n  = wr_data[DATA_W-1];
    assign flag_z  = in_wb & (wr_data == '0);

    assign stall   = busy | (start & ~flush);

endmodule
